// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU front end.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between IMEM responses and decode: {inst, pc} entries,
// flush beats push, push and pop are safe together at any occupancy.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output fetch_entry_t             head
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    fetch_entry_t last_q;
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         full;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When empty, the head shows the most recently written entry rather than a stale slot.
    assign head = empty ? last_q : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
                last_q <= din;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues credit-limited IMEM requests, buffers
// responses for decode, handles redirects and halts on misaligned fetch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        halt_fetch
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 2;

    logic [XLEN-1:0]             pc_q;
    logic                        inflight;
    logic [XLEN-1:0]             inflight_pc;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        empty;
    fetch_entry_t                head;
    fetch_entry_t                resp;
    logic                        pop;
    logic                        push;
    logic                        redirect_eff;
    logic [CW-1:0]               occupancy;
    logic                        credit;

    assign pop          = id_valid && id_ready;
    assign push         = inflight && !redirect_valid;
    assign redirect_eff = redirect_valid && !halt_fetch;

    // Slots already claimed (buffered + in flight) minus the one leaving this cycle.
    assign occupancy = CW'(count) + CW'(inflight) - CW'(pop);
    assign credit    = occupancy < CW'(FIFO_DEPTH);

    assign imem_req  = !rst && !halt_fetch && !redirect_valid && (pc_q[1:0] == 2'b00) && credit;
    assign imem_addr = pc_q;

    assign resp.inst = imem_rdata;
    assign resp.pc   = inflight_pc;

    assign id_valid = !empty;
    assign id_inst  = head.inst;
    assign id_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halt_fetch  <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (redirect_eff) begin
                pc_q <= redirect_pc;
            end else if (imem_req) begin
                pc_q        <= pc_q + 32'd4;
                inflight_pc <= pc_q;
            end
            if (!halt_fetch && (pc_q[1:0] != 2'b00) && !redirect_valid) begin
                halt_fetch <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_eff),
        .push  (push),
        .din   (resp),
        .pop   (pop),
        .count (count),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: per-cycle stimulus/expectation table
// plus a PC-wrap sequence on a second instance.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        halt_fetch;

    logic        rst_w;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        id_valid_w;
    logic [31:0] id_inst_w;
    logic [31:0] id_pc_w;
    logic        halt_fetch_w;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .halt_fetch     (halt_fetch)
    );

    fetch_stage #(
        .RESET_PC   (32'hFFFF_FFFC),
        .FIFO_DEPTH (2)
    ) dut_w (
        .clk            (clk),
        .rst            (rst_w),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_rdata     (imem_rdata_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .id_valid       (id_valid_w),
        .id_ready       (1'b1),
        .id_inst        (id_inst_w),
        .id_pc          (id_pc_w),
        .halt_fetch     (halt_fetch_w)
    );

    // Synchronous IMEM models: word = 0x1000_0000 | address, one cycle after the request.
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= 32'h1000_0000 | imem_addr;
        if (imem_req_w) imem_rdata_w <= 32'h1000_0000 | imem_addr_w;
    end

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic        ca;
        logic [31:0] addr;
        logic        valid;
        logic        ci;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy,
                                logic req, logic ca, logic [31:0] addr,
                                logic valid, logic ci, logic [31:0] pc,
                                logic [31:0] inst, logic halt);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.ca = ca; v.addr = addr;
        v.valid = valid; v.ci = ci; v.pc = pc; v.inst = inst; v.halt = halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    localparam logic [31:0] B = 32'h1000_0000;

    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        //             rst rv rpc     rdy  req ca addr     vld ci pc       inst         halt
        // straight line
        vecs.push_back(mk(1, 0, 32'h0,  1,  0, 0, 32'h0,   0, 1, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h0,   0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h4,   0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h8,   1, 1, 32'h0,   B|32'h0,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'hC,   1, 1, 32'h4,   B|32'h4,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h10,  1, 1, 32'h8,   B|32'h8,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h14,  1, 1, 32'hC,   B|32'hC,      0));
        // reset mid-stream, then backpressure from N+2 for 5 cycles
        vecs.push_back(mk(1, 0, 32'h0,  0,  0, 0, 32'h0,   1, 1, 32'h10,  B|32'h10,     0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1, 1, 32'h0,   0, 1, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1, 1, 32'h4,   0, 0, 32'h0,   32'h0,        0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'h8, 1, 1, 32'h0,   B|32'h0,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h8,   1, 1, 32'h0,   B|32'h0,      0));
        // redirect to 0x40 while pc 4 is being consumed
        vecs.push_back(mk(0, 1, 32'h40, 1,  0, 1, 32'hC,   1, 1, 32'h4,   B|32'h4,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h40,  0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h44,  0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h48,  1, 1, 32'h40,  B|32'h40,     0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h4C,  1, 1, 32'h44,  B|32'h44,     0));
        // misaligned redirect, then an ignored redirect
        vecs.push_back(mk(0, 1, 32'h42, 1,  0, 1, 32'h50,  1, 1, 32'h48,  B|32'h48,     0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  0, 1, 32'h42,  0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h80, 1,  0, 1, 32'h42,  0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,  1,  0, 1, 32'h42,  0, 0, 32'h0,   32'h0,        1));
        // reset clears halt; fill FIFO to {0x10,0x14} then reset with it full
        vecs.push_back(mk(1, 0, 32'h0,  1,  0, 1, 32'h42,  0, 0, 32'h0,   32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h0,   0, 1, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h4,   0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h8,   1, 1, 32'h0,   B|32'h0,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'hC,   1, 1, 32'h4,   B|32'h4,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h10,  1, 1, 32'h8,   B|32'h8,      0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h14,  1, 1, 32'hC,   B|32'hC,      0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  0, 1, 32'h18,  1, 1, 32'h10,  B|32'h10,     0));
        vecs.push_back(mk(1, 0, 32'h0,  0,  0, 1, 32'h18,  1, 1, 32'h10,  B|32'h10,     0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h0,   0, 1, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h4,   0, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1, 1, 32'h8,   1, 1, 32'h0,   B|32'h0,      0));

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            if (vecs[i].ca)
                chk($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d.id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].valid});
            if (vecs[i].valid || vecs[i].ci) begin
                chk($sformatf("v%0d.id_pc", i), id_pc, vecs[i].pc);
                chk($sformatf("v%0d.id_inst", i), id_inst, vecs[i].inst);
            end
            chk($sformatf("v%0d.halt", i), {31'b0, halt_fetch}, {31'b0, vecs[i].halt});
            @(posedge clk);
            #1;
        end

        // PC wrap on the second instance
        rst_w = 1'b0;
        @(negedge clk);
        chk("wrap.N.req", {31'b0, imem_req_w}, 32'd1);
        chk("wrap.N.addr", imem_addr_w, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap.N1.addr", imem_addr_w, 32'h0000_0000);
        chk("wrap.N1.valid", {31'b0, id_valid_w}, 32'd0);
        @(negedge clk);
        chk("wrap.N2.valid", {31'b0, id_valid_w}, 32'd1);
        chk("wrap.N2.pc", id_pc_w, 32'hFFFF_FFFC);
        chk("wrap.N2.inst", id_inst_w, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap.N3.pc", id_pc_w, 32'h0000_0000);
        chk("wrap.N3.inst", id_inst_w, 32'h1000_0000);
        chk("wrap.N3.halt", {31'b0, halt_fetch_w}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end for the pipelined successor to the single-cycle CPU.
- Owns the PC and issues word requests to the synchronous instruction memory (IMEM); read data returns one cycle after the request.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts redirects (branch/jump) from execute and raises a sticky halt on a misaligned fetch address.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request this cycle
imem_addr  output  32  byte address of request (equals pc_q)
imem_rdata  input  32  instruction word, valid the cycle after imem_req
redirect_valid  input  1  execute requests PC change
redirect_pc  input  32  new fetch target
id_valid  output  1  id_inst/id_pc hold a valid instruction
id_ready  input  1  decode accepts this cycle
id_inst  output  32  instruction at FIFO head
id_pc  output  32  PC of id_inst
halt_fetch  output  1  sticky: misaligned fetch detected

Behaviour:
- Reset (rst high at a clock edge):
  - pc_q=RESET_PC; FIFO empty; in-flight flag cleared; halt_fetch=0.
  - Outputs: id_valid=0, id_inst=0, id_pc=0, imem_req=0.
  - Reset mid-operation discards every buffered and in-flight word.
- State:
  - pc_q.
  - inflight (1 bit) plus inflight_pc (32 bits).
  - FIFO: entries {inst, pc}, read/write pointers of log2(FIFO_DEPTH)+1 bits, wrap-around by pointer MSB.
- Pop: id_valid && id_ready in a cycle removes the head at the end of that cycle.
- Credit rule (combinational):
  - imem_req = !rst && !halt_fetch && !redirect_valid && (pc_q[1:0]==0) && (count + inflight - pop < FIFO_DEPTH).
  - This guarantees every response has a free slot; overflow is impossible by construction.
- Request accepted (imem_req=1): at the edge, inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^32).
- Response: in the cycle after a request, if inflight && !redirect_valid, write {imem_rdata, inflight_pc} into the FIFO.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty.
- Latency:
  - First cycle with rst low (N): imem_req=1, imem_addr=RESET_PC.
  - N+1: word pushed.
  - N+2: id_valid=1.
  - Steady-state throughput is 1 instruction/cycle with FIFO_DEPTH=2 and id_ready held high.
- Stall: id_ready low holds id_inst/id_pc/id_valid stable. Requests stop once credits are exhausted and resume the cycle after a pop frees one.
- Redirect (redirect_valid high in cycle R):
  - Highest priority. At the edge: FIFO flushed, in-flight response discarded, pc_q<=redirect_pc.
  - No request in R; the first request to redirect_pc is in R+1, with id_valid earliest in R+3.
  - A pop handshake occurring in R still counts as consumed by decode.
  - Redirect overrides a simultaneous push.
  - Back-to-back redirects: the last one wins.
- Misaligned:
  - If !halt_fetch && pc_q[1:0]!=0 && !redirect_valid, set halt_fetch at the edge.
  - No request is ever issued to a misaligned address.
  - The FIFO continues to drain to decode.
  - halt_fetch stays 1 until rst, including across later redirects (redirects are ignored once halted).
- Empty FIFO: id_valid=0. id_inst/id_pc are don't-care but must equal the last-written entry (no X).

Decomposition:
- Package cpu_pkg:
  - XLEN=32, INST_NOP=32'h0000_0013, RESET_PC_DEFAULT.
  - Typedef fetch_entry_t {inst[31:0], pc[31:0]}.
- Sub-module fetch_fifo (parameter DEPTH): push/pop/flush, count, head outputs. Flush has priority over push; pop and push are simultaneous-safe.
- PC/credit/halt logic stays in fetch_stage.

Test Plan:
- Straight line, IMEM model returning 32'h1000_0000|addr, id_ready=1: after reset, id_pc sequence 0,4,8,0xC on consecutive cycles starting N+2; imem_req never drops.
- Backpressure, id_ready=0 for 5 cycles from N+2: id_pc holds 0, imem_req=0 after 2 requests. Raising id_ready gives id_pc 0,4,8 with no duplicates or gaps.
- Redirect to 0x40 in the cycle id_pc=4 is accepted:
  - pc 4 counts as consumed.
  - imem_addr=0x40 next cycle.
  - id_pc after redirect is 0x40, then 0x44; never 8.
- Redirect to 0x42:
  - halt_fetch=1 one cycle later.
  - imem_req stays 0.
  - A further redirect to 0x80 is ignored.
  - Remaining FIFO entries still drain.
- Reset asserted for one cycle with FIFO full (pcs 0x10,0x14): next cycle id_valid=0, halt_fetch=0, then refetch from RESET_PC=0.
- PC wrap, RESET_PC=32'hFFFF_FFFC: id_pc sequence 0xFFFF_FFFC, then 0x0000_0000.
